instr_cycle_sequencer: RTL

// Multicycle sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB.

---
 rtl/seq_pkg.sv | 42 ++++
 rtl/seq_wait_timer.sv | 31 +++
 rtl/instr_cycle_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and opcode classification for the multicycle instruction sequencer.
// The FSM decides timing only; field decoding stays in the combinational decoder.
package seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT,
    S_TRAP
  } seq_state_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: is_legal = 1'b1;
      default:                               is_legal = 1'b0;
    endcase
  endfunction

  // Stores and branches are the only legal instructions without a destination register.
  function automatic logic writes_rd(input logic [6:0] opc);
    writes_rd = is_legal(opc) && (opc != OPC_STORE) && (opc != OPC_BRANCH);
  endfunction

  function automatic logic is_mem(input logic [6:0] opc);
    is_mem = (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts cycles a memory request has waited without an ack.
// expired is high during the WAIT_MAX-th such cycle, so an ack in that cycle still wins.
module seq_wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/instr_cycle_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I core.
// Outputs are registered alongside the state; only IRWr also qualifies on IMemAck.
module instr_cycle_sequencer
  import seq_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       Opcode,
  input  logic             Halt,
  input  logic             IMemAck,
  input  logic             DMemAck,
  output logic             IMemReq,
  output logic             DMemReq,
  output logic             IRWr,
  output logic             PCWr,
  output logic             RUWr,
  output logic             DMWr,
  output logic             Illegal,
  output logic             BusErr,
  output logic             Halted,
  output logic [CNT_W-1:0] Retired
);

  seq_state_t       state;
  logic             imem_req_q, dmem_req_q, dmwr_q, pcwr_q, ruwr_q;
  logic             illegal_q, buserr_q, halted_q;
  logic [CNT_W-1:0] retired_q;
  logic             expired;

  seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!(imem_req_q || dmem_req_q)),
    .en      ((imem_req_q && !IMemAck) || (dmem_req_q && !DMemAck)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmwr_q     <= 1'b0;
      pcwr_q     <= 1'b0;
      ruwr_q     <= 1'b0;
      illegal_q  <= 1'b0;
      buserr_q   <= 1'b0;
      halted_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      case (state)
        // Out of reset the request is raised one cycle into FETCH; afterwards it is
        // raised on the transition into FETCH so there is no bubble.
        S_FETCH: begin
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (IMemAck) begin
            imem_req_q <= 1'b0;
            state      <= S_DECODE;
          end else if (expired) begin
            imem_req_q <= 1'b0;
            buserr_q   <= 1'b1;
            state      <= S_TRAP;
          end
        end
        S_DECODE: begin
          if (is_legal(Opcode)) begin
            state <= S_EXECUTE;
          end else begin
            illegal_q <= 1'b1;
            state     <= S_TRAP;
          end
        end
        S_EXECUTE: begin
          if (is_mem(Opcode)) begin
            dmem_req_q <= 1'b1;
            dmwr_q     <= (Opcode == OPC_STORE);
            state      <= S_MEM;
          end else begin
            pcwr_q <= 1'b1;
            ruwr_q <= writes_rd(Opcode);
            state  <= S_WB;
          end
        end
        S_MEM: begin
          if (DMemAck) begin
            dmem_req_q <= 1'b0;
            dmwr_q     <= 1'b0;
            pcwr_q     <= 1'b1;
            ruwr_q     <= writes_rd(Opcode);
            state      <= S_WB;
          end else if (expired) begin
            dmem_req_q <= 1'b0;
            dmwr_q     <= 1'b0;
            buserr_q   <= 1'b1;
            state      <= S_TRAP;
          end
        end
        S_WB: begin
          pcwr_q    <= 1'b0;
          ruwr_q    <= 1'b0;
          retired_q <= retired_q + 1'b1;
          if (Halt) begin
            halted_q <= 1'b1;
            state    <= S_HALT;
          end else begin
            imem_req_q <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_HALT: begin
          if (!Halt) begin
            halted_q   <= 1'b0;
            imem_req_q <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

  assign IMemReq = imem_req_q;
  assign DMemReq = dmem_req_q;
  assign IRWr    = imem_req_q && IMemAck;
  assign PCWr    = pcwr_q;
  assign RUWr    = ruwr_q;
  assign DMWr    = dmwr_q;
  assign Illegal = illegal_q;
  assign BusErr  = buserr_q;
  assign Halted  = halted_q;
  assign Retired = retired_q;

endmodule
